mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath, owning the HI/LO registers. It sits beside the single-cycle ALU in the EX stage and takes the same din1/din2 operands. Unlike the ALU, it is multi-cycle: a start/busy/done handshake lets the hazard unit stall mfhi/mflo until results are ready. It serves mult, multu, div, divu, mthi and mtlo.

Parameters:
WIDTH, 32, operand and HI/LO width; the only supported value is 32.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only while idle
mduOp  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved
din1  input  32  rs operand (multiplicand / dividend / mthi-mtlo source)
din2  input  32  rt operand (multiplier / divisor)
cancel  input  1  exception flush; aborts an in-flight operation
busy  output  1  high while an iterative operation is in flight
done  output  1  one-cycle pulse when HI/LO receive a mult/div result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, RUN.
- IDLE, start=1, cancel=0, mduOp in {000..011}, accepted at edge E0:
  - latch operand magnitudes (signed ops: absolute values) and the result signs;
  - go to RUN; busy=1 from E0; counter=0.
- IDLE, start=1, cancel=0, mduOp=100/101: at E0 hi (resp. lo) := din1; the other register is unchanged; no busy, no done.
- IDLE, reserved mduOp, or start with cancel=1: no effect.
- RUN:
  - one radix-2 step per edge: shift-add multiply, or restoring divide;
  - step k performed at edge E(k), k=1..32.
  - At E32: write the sign-corrected result to hi/lo; done=1 for exactly the cycle after E32; busy=0 after E32; return to IDLE.
  - A new start can be accepted at the edge after E32, so back-to-back issue has a 1-cycle gap.
- Latency: 32 cycles from acceptance to done; hi/lo are valid in the same cycle done is high.
- start while busy: ignored and not queued. The issuer must hold the instruction until busy=0.
- cancel=1 while busy: at the next edge go to IDLE, busy=0, no done, hi/lo unchanged. cancel in the same cycle as E32: cancel wins and hi/lo are not written.
- Multiply: full 64-bit product, hi=[63:32], lo=[31:0]. Signed products are negated when the operand signs differ. mult 0x8000_0000 × 0x8000_0000 gives hi=0x4000_0000, lo=0.
- Divide: lo=quotient, hi=remainder. Signed: quotient sign = sign(din1) xor sign(din2); remainder sign = sign(din1).
  - 0x8000_0000 / 0xFFFF_FFFF (div) gives lo=0x8000_0000, hi=0.
  - Divide by zero is deterministic with no exception: the magnitude quotient is 0xFFFF_FFFF and the magnitude remainder is |din1|, then sign correction applies. divu x/0 gives lo=0xFFFF_FFFF, hi=x.
- No arithmetic exceptions are raised; overflow is architecturally ignored.
- hi/lo hold their values between operations. Outputs are registered with no combinational path from start to busy.

Decomposition:
- Shared package mdu_pkg:
  - mduOp encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO;
  - state encoding IDLE/RUN;
  - WIDTH constant.
- Optional sub-module mdu_step: the combinational single-iteration datapath (add-shift or trial-subtract), selected by an isDiv flag.
- The control FSM, counter, sign fix-up and HI/LO stay in mul_div_unit.

Test Plan:
- mult din1=0xFFFF_FFFF, din2=2 → done at acceptance+32 cycles, hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. multu with the same operands → hi=0x0000_0001, lo=0xFFFF_FFFE.
- div din1=0xFFFF_FFF9 (−7), din2=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. divu din1=100, din2=7 → lo=0x0000_000E, hi=0x0000_0002.
- divu din1=0x1234_5678, din2=0 → lo=0xFFFF_FFFF, hi=0x1234_5678. div 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- mthi din1=0xABCD_0000, then mtlo din1=5 → hi=0xABCD_0000 and lo=5 one edge after each; busy and done stay 0.
- Start multu 3×4; at cycle 10 pulse start with div, and at cycle 20 assert cancel → busy=0 next cycle, no done, hi/lo keep their prior values. A following multu 3×4 gives lo=12, hi=0.
- Assert rst asynchronously mid-RUN (between edges) → busy, done, hi and lo are 0 immediately; no done pulse after rst is released.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// encoding and the operand width.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Magnitude of an operand; only negated when the op is signed and the MSB is set.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step,
// sharing a single adder between the two modes.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] sh_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] sh_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] opa;
    logic [WIDTH:0] opb;
    logic [WIDTH:0] res;
    logic           fits;

    // Divide: trial = partial remainder with the next dividend bit shifted in.
    assign trial = {acc_i, sh_i[WIDTH-1]};
    assign fits  = (trial >= {1'b0, b_i});

    always_comb begin
        opa = {1'b0, acc_i};
        opb = '0;
        if (is_div_i) begin
            opa = trial;
            opb = ~{1'b0, b_i};
        end else if (sh_i[0]) begin
            opb = {1'b0, b_i};
        end
    end

    assign res = opa + opb + {{WIDTH{1'b0}}, is_div_i};

    always_comb begin
        if (is_div_i) begin
            acc_o = fits ? res[WIDTH-1:0] : trial[WIDTH-1:0];
            sh_o  = {sh_i[WIDTH-2:0], fits};
        end else begin
            acc_o = res[WIDTH:1];
            sh_o  = {res[0], sh_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. One radix-2 step per cycle,
// 32 steps per operation, with a start/busy/done handshake and cancel.
module mul_div_unit #(
    parameter int WIDTH = mdu_pkg::WIDTH,
    parameter int CNT_W = mdu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mduOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mdu_pkg::*;

    // Handshake: start is sampled only in IDLE; busy is high from the accept
    // edge until the final step; done pulses one cycle with HI/LO valid.
    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept_op;
    logic               accept_mv;
    logic               last_step;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_sh;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept_op = (state_q == IDLE) && start && !cancel && !mduOp[2];
    assign accept_mv = (state_q == IDLE) && start && !cancel &&
                       ((mduOp == MDU_MTHI) || (mduOp == MDU_MTLO));
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    assign sgn_op = !mduOp[0];
    assign a_neg  = sgn_op && din1[WIDTH-1];
    assign b_neg  = sgn_op && din2[WIDTH-1];

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(is_div_q),
        .acc_i   (acc_q),
        .sh_i    (sh_q),
        .b_i     (b_q),
        .acc_o   (step_acc),
        .sh_o    (step_sh)
    );

    // Sign fix-up applied to the result of the final step.
    assign prod_mag = {step_acc, step_sh};
    assign prod_fix = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix  = neg_res_q ? (~step_sh + 1'b1) : step_sh;
    assign rem_fix  = neg_rem_q ? (~step_acc + 1'b1) : step_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_op) state_d = RUN;
            RUN:  if (cancel || last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        if (accept_op) begin
            cnt_d     = '0;
            is_div_d  = mduOp[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            b_d       = mag(din2, b_neg);
            sh_d      = mag(din1, a_neg);
            acc_d     = '0;
        end else if (accept_mv) begin
            if (mduOp == MDU_MTHI) hi_d = din1;
            else                   lo_d = din1;
        end else if (state_q == RUN) begin
            if (cancel) begin
                cnt_d = '0;
            end else begin
                acc_d = step_acc;
                sh_d  = step_sh;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = prod_fix[WIDTH-1:0];
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a transaction-level model checked every
// cycle, plus literal expectations from hand-worked examples.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mduOp = 3'b000;
    logic [31:0] din1 = '0;
    logic [31:0] din2 = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mduOp (mduOp),
        .din1  (din1),
        .din2  (din2),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain arithmetic.
    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin p = sa * sb; return 64'(p); end
            3'b001: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
            3'b010: begin
                if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Transaction model: an accepted op completes 32 edges later unless cancelled.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_hi   = m_res[63:32];
                        m_lo   = m_res[31:0];
                    end
                end
            end else if (start && !cancel) begin
                if (mduOp <= 3'b011) begin
                    m_res  = model_res(mduOp, din1, din2);
                    m_busy = 1'b1;
                    m_left = 32;
                end else if (mduOp == 3'b100) begin
                    m_hi = din1;
                end else if (mduOp == 3'b101) begin
                    m_lo = din1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (done) done_seen++;
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; mduOp = op; din1 = a; din2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int lat;
        issue(op, a, b);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd32);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;

        run_op("mult_m1x2",  3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_m1x2", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_min2",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
        run_op("div_m7_2",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_by0",   3'b011, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div_7_m2",   3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("mult_m3x5",  3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu_max_1", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
        run_op("div_m9_by0", 3'b010, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'd1);

        issue(3'b100, 32'hABCD_0000, 32'd0);
        check("mthi_hi", hi, 32'hABCD_0000);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'b101, 32'd5, 32'd0);
        check("mtlo_lo", lo, 32'd5);
        check("mtlo_hi", hi, 32'hABCD_0000);

        // Reserved op and start-with-cancel leave everything untouched.
        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        start = 1'b1; mduOp = 3'b100; din1 = 32'h1111_1111; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("nop_hi", hi, 32'hABCD_0000);
        check("nop_lo", lo, 32'd5);

        // Cancel mid-run; the div pulsed while busy must be ignored.
        done_seen = 0;
        issue(3'b001, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        start = 1'b1; mduOp = 3'b010; din1 = 32'd50; din2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, 32'hABCD_0000);
        check("cancel_lo", lo, 32'd5);
        repeat (40) @(negedge clk);
        check("cancel_no_done", 32'(done_seen), 32'd0);
        run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12);

        // Async reset between edges while running.
        issue(3'b000, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        done_seen = 0;
        repeat (40) @(negedge clk);
        check("arst_no_done", 32'(done_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
